icache: RTL
===========

// Module: icache
// PURPOSE
//  Direct-mapped instruction cache directly upstream of the fetcher. It answers the fetcher's PC lookup
//  combinationally and in the same cycle. Fills come only from fetcher-issued memory fetches.
//  The memory controller's returned instruction is written back, tagged with the PC captured when the
//  miss was issued. Entries are halfword-indexed so C-extension PCs (pc[0]=0, pc[1]=1) cache independently.
// PARAMETERS
//  IDX_W    8   index bits; ENTRIES = 2**IDX_W
//  TAG_W    31-IDX_W   tag bits = pc[31:IDX_W+1] (derived, do not override)
// PORTS
//  clk                input   1   clock
//  rst                input   1   reset, synchronous, active-high
//  rdy                input   1   global ready; 0 freezes all state
//  fet_icache_enable  input   1   fetcher lookup valid
//  fet_pc             input   32  lookup PC; also miss PC when fet_mem_enable=1
//  fet_mem_enable     input   1   fetcher issues miss to memory controller this cycle (accepted)
//  mem_inst_ready     input   1   memory controller returns instruction this cycle
//  mem_inst           input   32  returned instruction word (raw, may hold 16-bit inst in [15:0])
//  icache_ready       output  1   hit: enable && valid[idx] && tag[idx]==pc tag && !rst
//  icache_inst        output  32  data[idx]; don't-care when icache_ready=0
//  icache_hit_cnt     output  32  (ICACHE_PERF_EN only) hit counter
//  icache_miss_cnt    output  32  (ICACHE_PERF_EN only) miss counter
// BEHAVIOUR
//  - idx = pc[IDX_W:1], tag = pc[31:IDX_W+1]; pc[0] ignored.
//  - Lookup is combinational, zero latency; icache_ready is forced 0 while rst=1.
//  - FSM {IDLE, WAIT}; pend_pc[31:0] register.
//      IDLE: fet_mem_enable -> pend_pc<=fet_pc, go WAIT.
//      WAIT: mem_inst_ready -> write {valid=1,tag(pend_pc),mem_inst} at idx(pend_pc), go IDLE.
//        If fet_mem_enable in the same cycle, capture the new pend_pc and stay WAIT.
//      WAIT & fet_mem_enable without mem_inst_ready: overwrite pend_pc (protocol error; bench asserts).
//  - mem_inst_ready in IDLE is ignored (no write).
//  - Fetcher flush does not cancel WAIT: the late response still fills at its own captured address.
//  - Write takes effect at the clock edge. A same-cycle lookup of the filled index sees the old contents.
//    The fetcher takes mem_inst directly that cycle, so no bypass is needed.
//  - Conflict: a fill overwrites the entry unconditionally (evicts any other tag).
//  - rdy=0: no FSM, array, or counter update; combinational outputs still driven.
//  - rst (rdy=1): all valid bits cleared in one cycle, FSM->IDLE, pend_pc->0, counters->0.
//    An outstanding response arriving after rst is dropped (state is IDLE).
//  - data/tag arrays are not reset; only valid bits are.
// CONFIGURATION
//  ICACHE_PERF_EN defined: adds icache_hit_cnt and icache_miss_cnt, both 32-bit and wrapping.
//    - hit_cnt +1 on each rdy cycle with fet_icache_enable && hit.
//    - miss_cnt +1 on each rdy cycle with fet_mem_enable.
//    - Both are cleared by rst.
//  ICACHE_PERF_EN undefined: these ports and counters do not exist; the rest of the behaviour is identical.
// STRUCTURE
//  - global_params.v: XLEN, ICACHE_IDX_W default, FSM state encodings ICACHE_IDLE/ICACHE_WAIT.
//  - Sub-module icache_array: valid flop vector + tag/data LUTRAM, one comb read port, one sync write
//    port, and a synchronous clear of valid. icache holds the FSM, pend_pc and the perf counters.
// TESTING
//  1. rst, then enable pc=0x0 -> icache_ready=0.
//  2. fet_mem_enable pc=0x100; 3 cycles later mem_inst_ready inst=0x00500093
//     -> from the next cycle, lookup 0x100: ready=1, inst=0x00500093.
//  3. Fill 0x100, then fill 0x100+2*256=0x300 (same idx) -> lookup 0x300 hit, 0x100 miss.
//  4. Fill 0x102 with 0x00004501 -> 0x102 hit inst=0x00004501; 0x100 unaffected (miss if never filled).
//  5. Miss 0x200 outstanding; rst for 1 cycle; mem_inst_ready arrives -> no write, 0x200 miss, all lines invalid.
//  6. ICACHE_PERF_EN: 2 misses + 5 hit cycles, with rdy=0 for 2 of those hit cycles -> hit_cnt=3, miss_cnt=2.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and defaults for the direct-mapped instruction cache.
// Optional perf counters are built when ICACHE_PERF_EN is defined.
package icache_pkg;

  localparam int XLEN         = 32;
  localparam int ICACHE_IDX_W = 8;

  typedef enum logic {
    ICACHE_IDLE = 1'b0,
    ICACHE_WAIT = 1'b1
  } icache_state_e;

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage: one combinational read port, one sync write
// port, and a single-cycle synchronous clear of the valid bits.
module icache_array
  import icache_pkg::*;
#(
  parameter int IDX_W = ICACHE_IDX_W,
  parameter int TAG_W = 31 - IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [XLEN-1:0]  rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [XLEN-1:0]  wr_data
);

  localparam int ENTRIES = 1 << IDX_W;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_mem  [ENTRIES];
  logic [XLEN-1:0]    data_mem [ENTRIES];

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx];

  always_ff @(posedge clk) begin
    if (rdy) begin
      if (rst) begin
        valid_q <= '0;
      end else if (wr_en) begin
        valid_q[wr_idx] <= 1'b1;
      end
    end
  end

  // Tag/data carry no reset so they map onto LUTRAM.
  always_ff @(posedge clk) begin
    if (rdy && !rst && wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/icache.sv
// Direct-mapped, halfword-indexed instruction cache with miss tracking.
// Define ICACHE_PERF_EN to add the hit/miss counter ports.
module icache
  import icache_pkg::*;
#(
  parameter int IDX_W = ICACHE_IDX_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            fet_icache_enable,
  input  logic [XLEN-1:0] fet_pc,
  input  logic            fet_mem_enable,
  input  logic            mem_inst_ready,
  input  logic [XLEN-1:0] mem_inst,
  output logic            icache_ready,
  output logic [XLEN-1:0] icache_inst
`ifdef ICACHE_PERF_EN
  ,
  output logic [XLEN-1:0] icache_hit_cnt,
  output logic [XLEN-1:0] icache_miss_cnt
`endif
);

  localparam int TAG_W = 31 - IDX_W;

  icache_state_e   state_q, state_d;
  logic [XLEN-1:0] pend_q, pend_d;
  logic            fill_en;
  logic            rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic            hit;
  logic            unused_pc0;

  // Bit 0 never selects a distinct halfword.
  assign unused_pc0 = fet_pc[0] ^ pend_q[0];

  icache_array #(
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .rd_idx   (fet_pc[IDX_W:1]),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (icache_inst),
    .wr_en    (fill_en),
    .wr_idx   (pend_q[IDX_W:1]),
    .wr_tag   (pend_q[31:IDX_W+1]),
    .wr_data  (mem_inst)
  );

  assign hit = rd_valid && (rd_tag == fet_pc[31:IDX_W+1]);
  assign icache_ready = fet_icache_enable && hit && !rst;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    fill_en = 1'b0;
    unique case (state_q)
      ICACHE_IDLE: begin
        if (fet_mem_enable) begin
          pend_d  = fet_pc;
          state_d = ICACHE_WAIT;
        end
      end
      ICACHE_WAIT: begin
        if (mem_inst_ready) begin
          fill_en = 1'b1;
          state_d = ICACHE_IDLE;
        end
        // A new miss may be issued in the response cycle.
        if (fet_mem_enable) begin
          pend_d  = fet_pc;
          state_d = ICACHE_WAIT;
        end
      end
      default: state_d = ICACHE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rdy) begin
      if (rst) begin
        state_q <= ICACHE_IDLE;
        pend_q  <= '0;
      end else begin
        state_q <= state_d;
        pend_q  <= pend_d;
      end
    end
  end

`ifdef ICACHE_PERF_EN
  always_ff @(posedge clk) begin
    if (rdy) begin
      if (rst) begin
        icache_hit_cnt  <= '0;
        icache_miss_cnt <= '0;
      end else begin
        if (fet_icache_enable && hit) begin
          icache_hit_cnt <= icache_hit_cnt + 32'd1;
        end
        if (fet_mem_enable) begin
          icache_miss_cnt <= icache_miss_cnt + 32'd1;
        end
      end
    end
  end
`else
`endif

endmodule
